// File: rtl/mcp_dac_pkg.sv
// Shared MCP49x2 command-word layout and command nibbles, used by the DAC receiver
// and the DDS-side transmitter.
package mcp_dac_pkg;
   localparam int unsigned CH_BIT     = 15;
   localparam int unsigned BUF_BIT    = 14;
   localparam int unsigned GA_N_BIT   = 13;
   localparam int unsigned SHDN_N_BIT = 12;
   localparam int unsigned DATA_MSB   = 11;
   localparam int unsigned FRAME_BITS = 16;

   // Upper nibble {ch, buf, ga_n, shdn_n}
   localparam logic [3:0] CMD_A_2X_ON = 4'b0001;
   localparam logic [3:0] CMD_A_1X_ON = 4'b0011;
   localparam logic [3:0] CMD_A_OFF   = 4'b0010;
   localparam logic [3:0] CMD_B_2X_ON = 4'b1001;
   localparam logic [3:0] CMD_B_1X_ON = 4'b1011;
   localparam logic [3:0] CMD_B_OFF   = 4'b1010;

   typedef enum logic [1:0] {
      WAIT_HI,
      IDLE,
      SHIFT
   } rx_state_t;
endpackage

// File: rtl/mcp_dac_rx_if.sv
// SPI mode-0 bus between the DDS transmitter (master) and the DAC receiver (slave).
interface mcp_dac_rx_if;
   logic sclk;
   logic mosi;
   logic cs;

   modport master (output sclk, mosi, cs);
   modport slave  (input  sclk, mosi, cs);
endinterface

// File: rtl/mcp_dac_rx_shift.sv
// SPI framing for the DAC receiver: input sync, edge strobes, framing FSM, shift register
// and bit counter. frame_done/frame_bad/word are valid in the cycle cs_rise is processed.
module mcp_dac_rx_shift
   import mcp_dac_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   mcp_dac_rx_if.slave           spi,
   output logic                  frame_done,
   output logic                  frame_bad,
   output logic [FRAME_BITS-1:0] word
);
   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

   logic sclk_s, mosi_s, cs_s;
   logic sclk_q, cs_q, mosi_q;
   logic sclk_rise, cs_fall, cs_rise;

   // cs resets low so a frame cut by reset keeps the FSM in WAIT_HI
   mcp_dac_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_s));
   mcp_dac_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(spi.mosi), .q(mosi_s));
   mcp_dac_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs   (.clk(clk), .rst(rst), .d(spi.cs),   .q(cs_s));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q    <= 1'b0;
         cs_q      <= 1'b0;
         mosi_q    <= 1'b0;
         sclk_rise <= 1'b0;
         cs_fall   <= 1'b0;
         cs_rise   <= 1'b0;
      end else begin
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
         mosi_q    <= mosi_s;
         sclk_rise <= sclk_s & ~sclk_q;
         cs_fall   <= ~cs_s & cs_q;
         cs_rise   <= cs_s & ~cs_q;
      end
   end

   rx_state_t             state, state_nxt;
   logic [FRAME_BITS-1:0] shift, shift_nxt;
   logic [4:0]            bit_cnt, bit_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= WAIT_HI;
         shift   <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         shift   <= shift_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // A bit arriving with cs_rise is shifted and counted before the frame is judged
   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift;
      bit_cnt_nxt = bit_cnt;
      frame_done  = 1'b0;
      frame_bad   = 1'b0;
      case (state)
         WAIT_HI: if (cs_s) state_nxt = IDLE;
         IDLE: begin
            if (cs_fall) begin
               bit_cnt_nxt = '0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               shift_nxt = {shift[FRAME_BITS-2:0], mosi_q};
               if (bit_cnt != CNT_SAT) bit_cnt_nxt = bit_cnt + 5'd1;
            end
            if (cs_rise) begin
               frame_done = (bit_cnt_nxt == CNT_FULL);
               frame_bad  = (bit_cnt_nxt != CNT_FULL);
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = WAIT_HI;
      endcase
   end

   assign word = shift_nxt;
endmodule

// File: rtl/mcp_dac_sync.sv
// Multi-stage flip-flop synchronizer for a single asynchronous input.
module mcp_dac_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= {STAGES{RST_VAL}};
      else     ff <= (ff << 1) | STAGES'(d);
   end

   assign q = ff[STAGES-1];
endmodule

// File: rtl/mcp_dac_rx.sv
// MCP49x2 dual-DAC receiver: decodes SPI command words into per-channel registers.
// Optional LDAC latch stage is built when MCP_DAC_RX_LDAC_EN is defined.
module mcp_dac_rx
   import mcp_dac_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 10,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mcp_dac_rx_if.slave          spi,
`ifdef MCP_DAC_RX_LDAC_EN
   input  logic                 ldac_n,
`endif
   output logic [DATA_BITS-1:0] dac_a,
   output logic [DATA_BITS-1:0] dac_b,
   output logic                 gain2x_a,
   output logic                 gain2x_b,
   output logic                 on_a,
   output logic                 on_b,
   output logic                 word_valid,
   output logic                 word_ch,
   output logic                 frame_err
);
   logic                  frame_done, frame_bad;
   logic [FRAME_BITS-1:0] word;

   mcp_dac_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
      .clk        (clk),
      .rst        (rst),
      .spi        (spi),
      .frame_done (frame_done),
      .frame_bad  (frame_bad),
      .word       (word)
   );

   logic                 dec_ch, dec_gain2x, dec_on;
   logic [DATA_BITS-1:0] dec_data;
   logic                 unused_word;

   assign dec_ch      = word[CH_BIT];
   assign dec_gain2x  = ~word[GA_N_BIT];
   assign dec_on      = word[SHDN_N_BIT];
   assign dec_data    = word[DATA_MSB -: DATA_BITS];
   assign unused_word = ^word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         word_ch    <= 1'b0;
      end else begin
         word_valid <= frame_done;
         frame_err  <= frame_bad;
         if (frame_done) word_ch <= dec_ch;
      end
   end

`ifdef MCP_DAC_RX_LDAC_EN
   logic                 ldac_s;
   logic [DATA_BITS-1:0] lat_dac_a, lat_dac_b;
   logic                 lat_gain2x_a, lat_gain2x_b, lat_on_a, lat_on_b;

   mcp_dac_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ldac (.clk(clk), .rst(rst), .d(ldac_n), .q(ldac_s));

   // Outputs copy the latches as they stood before this cycle's decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_dac_a <= '0; lat_gain2x_a <= 1'b0; lat_on_a <= 1'b0;
         lat_dac_b <= '0; lat_gain2x_b <= 1'b0; lat_on_b <= 1'b0;
         dac_a     <= '0; gain2x_a     <= 1'b0; on_a     <= 1'b0;
         dac_b     <= '0; gain2x_b     <= 1'b0; on_b     <= 1'b0;
      end else begin
         if (frame_done && !dec_ch) begin
            lat_dac_a <= dec_data; lat_gain2x_a <= dec_gain2x; lat_on_a <= dec_on;
         end
         if (frame_done && dec_ch) begin
            lat_dac_b <= dec_data; lat_gain2x_b <= dec_gain2x; lat_on_b <= dec_on;
         end
         if (!ldac_s) begin
            dac_a <= lat_dac_a; gain2x_a <= lat_gain2x_a; on_a <= lat_on_a;
            dac_b <= lat_dac_b; gain2x_b <= lat_gain2x_b; on_b <= lat_on_b;
         end
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dac_a <= '0; gain2x_a <= 1'b0; on_a <= 1'b0;
         dac_b <= '0; gain2x_b <= 1'b0; on_b <= 1'b0;
      end else if (frame_done) begin
         if (!dec_ch) begin
            dac_a <= dec_data; gain2x_a <= dec_gain2x; on_a <= dec_on;
         end else begin
            dac_b <= dec_data; gain2x_b <= dec_gain2x; on_b <= dec_on;
         end
      end
   end
`endif
endmodule

// File: tb/tb_mcp_dac_rx.sv
// Directed bench for mcp_dac_rx: SPI mode-0 frames at sclk = clk/8, checked with
// immediate assertions; the LDAC scenario is built when MCP_DAC_RX_LDAC_EN is defined.
module tb_mcp_dac_rx;
   localparam int unsigned DATA_BITS   = 10;
   localparam int unsigned SYNC_STAGES = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [DATA_BITS-1:0] dac_a, dac_b;
   logic                 gain2x_a, gain2x_b, on_a, on_b;
   logic                 word_valid, word_ch, frame_err;
`ifdef MCP_DAC_RX_LDAC_EN
   logic                 ldac_n = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int wv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int wv0, fe0, lat;

   mcp_dac_rx_if spi_if ();

   mcp_dac_rx #(.DATA_BITS(DATA_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi        (spi_if),
`ifdef MCP_DAC_RX_LDAC_EN
      .ldac_n     (ldac_n),
`endif
      .dac_a      (dac_a),
      .dac_b      (dac_b),
      .gain2x_a   (gain2x_a),
      .gain2x_b   (gain2x_b),
      .on_a       (on_a),
      .on_b       (on_b),
      .word_valid (word_valid),
      .word_ch    (word_ch),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_valid) wv_cnt++;
      if (frame_err) fe_cnt++;
      if (word_valid && frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clock_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         spi_if.mosi = bits[i];
         #40 spi_if.sclk = 1'b1;
         #40 spi_if.sclk = 1'b0;
      end
   endtask

   // cs stays high for gap+1 clk cycles before the next frame may start
   task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
      @(negedge clk);
      spi_if.cs = 1'b0;
      #100;
      clock_bits(bits, n);
      #40;
      @(negedge clk);
      spi_if.cs = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   logic [15:0] b2b [10] = '{16'h1004, 16'h9008, 16'h2010, 16'hB020, 16'h1040,
                             16'h9080, 16'h3100, 16'hB200, 16'h3FFC, 16'hA004};

   initial begin
      spi_if.sclk = 1'b0;
      spi_if.mosi = 1'b0;
      spi_if.cs   = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      check("rst_dac_a", 32'(dac_a), 32'h0);
      check("rst_dac_b", 32'(dac_b), 32'h0);
      check("rst_flags", {gain2x_a, gain2x_b, on_a, on_b, word_valid, word_ch, frame_err}, 32'h0);

      // 1: channel A frame, with latency measured from cs rising
      wv0 = wv_cnt;
      @(negedge clk);
      spi_if.cs = 1'b0;
      #100;
      clock_bits(32'h3AAC, 16);
      #40;
      @(negedge clk);
      spi_if.cs = 1'b1;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (word_valid && lat == 0) lat = c;
      end
      check("t1_latency", 32'(lat), 32'(SYNC_STAGES + 2));
      check("t1_wv_pulses", 32'(wv_cnt - wv0), 32'd1);
      check("t1_dac_a", 32'(dac_a), 32'h2AB);
      check("t1_gain2x_a", 32'(gain2x_a), 32'h0);
      check("t1_on_a", 32'(on_a), 32'h1);
      check("t1_word_ch", 32'(word_ch), 32'h0);
      check("t1_b_untouched", {22'h0, dac_b}, 32'h0);
      check("t1_b_flags", {gain2x_b, on_b}, 32'h0);

      // 2: channel B frame
      wv0 = wv_cnt;
      send_frame(32'h9554, 16, 10);
      check("t2_wv_pulses", 32'(wv_cnt - wv0), 32'd1);
      check("t2_dac_b", 32'(dac_b), 32'h155);
      check("t2_gain2x_b", 32'(gain2x_b), 32'h1);
      check("t2_on_b", 32'(on_b), 32'h1);
      check("t2_word_ch", 32'(word_ch), 32'h1);
      check("t2_a_kept", {dac_a, gain2x_a, on_a}, {22'h0, 10'h2AB, 2'b01} >> 0);

      // 3: short and long frames
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      send_frame(32'h0000_0FFF, 12, 10);
      check("t3_err_12", 32'(fe_cnt - fe0), 32'd1);
      send_frame(32'h0001_8000, 17, 10);
      check("t3_err_17", 32'(fe_cnt - fe0), 32'd2);
      check("t3_no_wv", 32'(wv_cnt - wv0), 32'd0);
      check("t3_dac_a", 32'(dac_a), 32'h2AB);
      check("t3_dac_b", 32'(dac_b), 32'h155);
      check("t3_word_ch", 32'(word_ch), 32'h1);

      // 4: reset in the middle of a frame, released with cs still low
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      @(negedge clk);
      spi_if.cs = 1'b0;
      #100;
      clock_bits(32'h3A, 8);
      rst = 1'b1;
      #20 rst = 1'b0;
      clock_bits(32'hAC, 8);
      #40;
      @(negedge clk);
      spi_if.cs = 1'b1;
      repeat (10) @(negedge clk);
      check("t4_no_wv", 32'(wv_cnt - wv0), 32'd0);
      check("t4_no_err", 32'(fe_cnt - fe0), 32'd0);
      check("t4_dacs", {dac_a, dac_b}, 32'h0);
      check("t4_flags", {gain2x_a, gain2x_b, on_a, on_b, word_ch}, 32'h0);
      send_frame(32'h3AAC, 16, 10);
      check("t4_next_wv", 32'(wv_cnt - wv0), 32'd1);
      check("t4_next_dac_a", 32'(dac_a), 32'h2AB);

      // 5: ten back-to-back frames, cs high for two cycles between them
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      for (int i = 0; i < 10; i++) send_frame(32'(b2b[i]), 16, 1);
      repeat (10) @(negedge clk);
      check("t5_wv_pulses", 32'(wv_cnt - wv0), 32'd10);
      check("t5_no_err", 32'(fe_cnt - fe0), 32'd0);
      check("t5_dac_a", 32'(dac_a), 32'h3FF);
      check("t5_a_flags", {gain2x_a, on_a}, 32'b01);
      check("t5_dac_b", 32'(dac_b), 32'h001);
      check("t5_b_flags", {gain2x_b, on_b}, 32'b00);
      check("t5_word_ch", 32'(word_ch), 32'h1);

`ifdef MCP_DAC_RX_LDAC_EN
      // 6: decoded frame held in the input latches until ldac_n strobes
      ldac_n = 1'b1;
      rst = 1'b1;
      #20 rst = 1'b0;
      repeat (6) @(negedge clk);
      wv0 = wv_cnt;
      send_frame(32'h3AAC, 16, 10);
      check("t6_wv_pulses", 32'(wv_cnt - wv0), 32'd1);
      check("t6_dac_a_held", 32'(dac_a), 32'h0);
      check("t6_on_a_held", 32'(on_a), 32'h0);
      ldac_n = 1'b0;
      repeat (SYNC_STAGES) @(negedge clk);
      check("t6_dac_a_early", 32'(dac_a), 32'h0);
      @(negedge clk);
      check("t6_dac_a_loaded", 32'(dac_a), 32'h2AB);
      check("t6_on_a_loaded", 32'(on_a), 32'h1);
      ldac_n = 1'b1;
`endif

      check("never_both", 32'(both_cnt), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
